// File: rtl/zx_ula_pkg.sv
// Shared ULA definitions: VRAM arbiter state encoding, default fetch phases
// and the active display area used by the screen controller.
package zx_ula_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE       = 2'd0,
    ARB_ATTR       = 2'd1,
    ARB_BITMAP     = 2'd2,
    ARB_STALL_WAIT = 2'd3
  } arb_state_e;

  localparam logic [3:0] ATTR_PHASE_DEF   = 4'd2;
  localparam logic [3:0] BITMAP_PHASE_DEF = 4'd4;
  localparam logic [3:0] GUARD_DEF        = 4'd2;

  localparam logic [8:0] H_ACTIVE = 9'd256;
  localparam logic [8:0] V_ACTIVE = 9'd192;

  // Inclusive window test on the 16-clk fetch cycle; lo > hi means the window wraps.
  function automatic logic phase_in_window(input logic [3:0] ph,
                                           input logic [3:0] lo,
                                           input logic [3:0] hi);
    logic hit_v;
    if (lo <= hi) begin
      hit_v = (ph >= lo) && (ph <= hi);
    end else begin
      hit_v = (ph >= lo) || (ph <= hi);
    end
    return hit_v;
  endfunction

endpackage

// File: rtl/zx_cpu_clkgen.sv
// CPU clock divider: toggles on odd phases, freezes high when a contended
// cycle is refused and resumes once the arbiter is back in IDLE.
module zx_cpu_clkgen (
  input  logic clk14,
  input  logic rst,
  input  logic phase_odd,
  input  logic stall_req,
  input  logic fsm_idle,
  output logic clkcpu,
  output logic cpu_stall
);

  logic q_r;
  logic stall_r;
  logic q_nxt_s;
  logic stall_nxt_s;

  // Divider and stall hold; contention is only evaluated on a 0->1 edge of q
  always_comb begin
    q_nxt_s     = q_r;
    stall_nxt_s = stall_r;
    if (phase_odd) begin
      if (stall_r) begin
        if (fsm_idle) begin
          q_nxt_s     = 1'b0;
          stall_nxt_s = 1'b0;
        end else begin
          q_nxt_s     = 1'b1;
          stall_nxt_s = 1'b1;
        end
      end else if (!q_r) begin
        q_nxt_s     = 1'b1;
        stall_nxt_s = stall_req;
      end else begin
        q_nxt_s     = 1'b0;
        stall_nxt_s = 1'b0;
      end
    end else begin
      q_nxt_s     = q_r;
      stall_nxt_s = stall_r;
    end
  end

  // Divider state register
  always_ff @(posedge clk14 or posedge rst) begin
    if (rst) begin
      q_r     <= 1'b0;
      stall_r <= 1'b0;
    end else begin
      q_r     <= q_nxt_s;
      stall_r <= stall_nxt_s;
    end
  end

  assign clkcpu    = q_r;
  assign cpu_stall = stall_r;

endmodule

// File: rtl/zx_vram_arbiter.sv
// VRAM slot scheduler: video attribute/bitmap fetch slots with priority over
// contended CPU cycles, which are delayed by freezing the CPU clock.
module zx_vram_arbiter
  import zx_ula_pkg::*;
#(
  parameter logic [3:0] ATTR_PHASE   = ATTR_PHASE_DEF,
  parameter logic [3:0] BITMAP_PHASE = BITMAP_PHASE_DEF,
  parameter logic [3:0] GUARD        = GUARD_DEF,
  parameter bit         CONTEND_EN   = 1'b1
) (
  input  logic       clk14,
  input  logic       rst,
  input  logic [3:0] phase,
  input  logic       fetch_en,
  input  logic       cpu_contend,
  output logic       clkcpu,
  output logic       cpu_stall,
  output logic       vid_sel,
  output logic       vram_rd,
  output logic       attr_stb,
  output logic       bitmap_stb
);

  localparam logic [3:0] PRE_PHASE = ATTR_PHASE - 4'd1;
  localparam logic [3:0] WIN_LO    = ATTR_PHASE - GUARD;
  localparam logic [3:0] WIN_HI    = BITMAP_PHASE + 4'd1;

  arb_state_e state_r;
  arb_state_e state_nxt_s;
  logic       sub_r;
  logic       sub_nxt_s;
  logic       slot_nxt_s;
  logic       idle_s;
  logic       in_win_s;
  logic       stall_req_s;
  logic       stall_s;
  logic       vid_sel_r;
  logic       vram_rd_r;
  logic       attr_stb_r;
  logic       bitmap_stb_r;

  // Contention window around the two fetch slots
  always_comb begin
    in_win_s    = phase_in_window(phase, WIN_LO, WIN_HI);
    stall_req_s = CONTEND_EN && cpu_contend && fetch_en && in_win_s;
  end

  // Slot FSM next state; sub selects the first or second clk of a 2-clk slot
  always_comb begin
    state_nxt_s = state_r;
    sub_nxt_s   = 1'b0;
    case (state_r)
      ARB_IDLE: begin
        if ((phase == PRE_PHASE) && fetch_en) begin
          state_nxt_s = ARB_ATTR;
        end else begin
          state_nxt_s = ARB_IDLE;
        end
      end
      ARB_ATTR: begin
        if (sub_r) begin
          state_nxt_s = ARB_BITMAP;
        end else begin
          state_nxt_s = ARB_ATTR;
          sub_nxt_s   = 1'b1;
        end
      end
      ARB_BITMAP: begin
        if (!sub_r) begin
          state_nxt_s = ARB_BITMAP;
          sub_nxt_s   = 1'b1;
        end else if (stall_s) begin
          state_nxt_s = ARB_STALL_WAIT;
        end else begin
          state_nxt_s = ARB_IDLE;
        end
      end
      ARB_STALL_WAIT: state_nxt_s = ARB_IDLE;
      default:        state_nxt_s = ARB_IDLE;
    endcase
    slot_nxt_s = (state_nxt_s == ARB_ATTR) || (state_nxt_s == ARB_BITMAP);
  end

  // FSM state and registered VRAM controls decoded from the next state
  always_ff @(posedge clk14 or posedge rst) begin
    if (rst) begin
      state_r      <= ARB_IDLE;
      sub_r        <= 1'b0;
      vid_sel_r    <= 1'b0;
      vram_rd_r    <= 1'b0;
      attr_stb_r   <= 1'b0;
      bitmap_stb_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      sub_r        <= sub_nxt_s;
      vid_sel_r    <= slot_nxt_s;
      vram_rd_r    <= slot_nxt_s;
      attr_stb_r   <= (state_nxt_s == ARB_ATTR) && sub_nxt_s;
      bitmap_stb_r <= (state_nxt_s == ARB_BITMAP) && sub_nxt_s;
    end
  end

  assign idle_s = (state_r == ARB_IDLE);

  zx_cpu_clkgen u_clkgen (
    .clk14     (clk14),
    .rst       (rst),
    .phase_odd (phase[0]),
    .stall_req (stall_req_s),
    .fsm_idle  (idle_s),
    .clkcpu    (clkcpu),
    .cpu_stall (stall_s)
  );

  assign cpu_stall  = stall_s;
  assign vid_sel    = vid_sel_r;
  assign vram_rd    = vram_rd_r;
  assign attr_stb   = attr_stb_r;
  assign bitmap_stb = bitmap_stb_r;

endmodule

// File: tb/tb_zx_vram_arbiter.sv
// Scoreboard bench for zx_vram_arbiter: a contended instance and a
// CONTEND_EN=0 instance share stimulus and are compared against a slot model.
module tb_zx_vram_arbiter;

  logic       clk14 = 1'b0;
  logic       rst   = 1'b0;
  logic [3:0] phase = 4'd0;
  logic       fetch_en = 1'b0;
  logic       cpu_contend = 1'b0;
  logic       clkcpu, cpu_stall, vid_sel, vram_rd, attr_stb, bitmap_stb;
  logic       clkcpu_n, cpu_stall_n, vid_sel_n, vram_rd_n, attr_stb_n, bitmap_stb_n;

  always #5 clk14 = ~clk14;

  zx_vram_arbiter dut (
    .clk14(clk14), .rst(rst), .phase(phase), .fetch_en(fetch_en), .cpu_contend(cpu_contend),
    .clkcpu(clkcpu), .cpu_stall(cpu_stall), .vid_sel(vid_sel), .vram_rd(vram_rd),
    .attr_stb(attr_stb), .bitmap_stb(bitmap_stb)
  );

  zx_vram_arbiter #(.CONTEND_EN(1'b0)) dut_nc (
    .clk14(clk14), .rst(rst), .phase(phase), .fetch_en(fetch_en), .cpu_contend(cpu_contend),
    .clkcpu(clkcpu_n), .cpu_stall(cpu_stall_n), .vid_sel(vid_sel_n), .vram_rd(vram_rd_n),
    .attr_stb(attr_stb_n), .bitmap_stb(bitmap_stb_n)
  );

  // slot counts remaining video clocks: 4,3 = attribute, 2,1 = bitmap
  typedef struct packed {
    logic [2:0] slot;
    logic       sw;
    logic       q;
    logic       stall;
  } mdl_t;

  mdl_t        m_c, m_n;
  logic [11:0] sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [3:0]  ph = 4'd0;
  logic        clk_prev = 1'b0;
  int          ncyc = 0, last_rise = 0, rise_gap = 0;
  int          stall_run = 0, last_stall = 0, max_stall = 0;
  logic [3:0]  attr_ph = 4'd0, bmp_ph = 4'd0;
  int          attr_cnt = 0, bmp_cnt = 0;
  logic        activity = 1'b0, stall_seen = 1'b0, nc_stall = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  function automatic mdl_t mstep(mdl_t m, logic [3:0] p, logic fe, logic cc, logic cen);
    mdl_t r;
    logic idle;
    r = m;
    idle = (m.slot == 3'd0) && !m.sw;
    if (p[0]) begin
      if (m.stall) begin
        if (idle) begin
          r.q = 1'b0;
          r.stall = 1'b0;
        end
      end else if (!m.q) begin
        r.q = 1'b1;
        r.stall = cen && cc && fe && (p <= 4'd5);
      end else begin
        r.q = 1'b0;
      end
    end
    if (m.slot != 3'd0) begin
      r.slot = m.slot - 3'd1;
      if (m.slot == 3'd1) r.sw = m.stall;
    end else if (m.sw) begin
      r.sw = 1'b0;
    end else if (p == 4'd1 && fe) begin
      r.slot = 3'd4;
    end
    return r;
  endfunction

  function automatic logic [5:0] mexp(mdl_t m);
    return {m.q, m.stall, m.slot != 3'd0, m.slot != 3'd0, m.slot == 3'd3, m.slot == 3'd1};
  endfunction

  task automatic cyc(input logic fe, input logic cc);
    logic [11:0] e;
    phase = ph;
    fetch_en = fe;
    cpu_contend = cc;
    m_c = mstep(m_c, ph, fe, cc, 1'b1);
    m_n = mstep(m_n, ph, fe, cc, 1'b0);
    sb_q.push_back({mexp(m_c), mexp(m_n)});
    @(posedge clk14);
    #1;
    e = sb_q.pop_front();
    check("sb_dut", {clkcpu, cpu_stall, vid_sel, vram_rd, attr_stb, bitmap_stb}, e[11:6]);
    check("sb_nocontend", {clkcpu_n, cpu_stall_n, vid_sel_n, vram_rd_n, attr_stb_n, bitmap_stb_n}, e[5:0]);
    if (clkcpu && !clk_prev) begin
      rise_gap = ncyc - last_rise;
      last_rise = ncyc;
      if (cc && fe && vid_sel) check("rise_vs_video", cpu_stall, 1);
    end
    clk_prev = clkcpu;
    ncyc++;
    if (cpu_stall) begin
      stall_run++;
      stall_seen = 1'b1;
    end else if (stall_run > 0) begin
      last_stall = stall_run;
      if (stall_run > max_stall) max_stall = stall_run;
      stall_run = 0;
    end
    if (attr_stb) begin
      attr_ph = ph + 4'd1;
      attr_cnt++;
    end
    if (bitmap_stb) begin
      bmp_ph = ph + 4'd1;
      bmp_cnt++;
    end
    activity = activity | vid_sel | vram_rd | attr_stb | bitmap_stb;
    nc_stall = nc_stall | cpu_stall_n;
    ph = ph + 4'd1;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #2;
    check(tag, {clkcpu, cpu_stall, vid_sel, vram_rd, attr_stb, bitmap_stb,
                clkcpu_n, cpu_stall_n, vid_sel_n, vram_rd_n, attr_stb_n, bitmap_stb_n}, 0);
    m_c = '0;
    m_n = '0;
    sb_q.delete();
    @(posedge clk14);
    #1;
    rst = 1'b0;
    ph = ph + 4'd1;
    clk_prev = 1'b0;
    stall_run = 0;
  endtask

  initial begin
    #1;
    do_reset("reset_values");
    ph = 4'd0;

    // free-running video fetch, no contention
    stall_seen = 1'b0;
    for (int i = 0; i < 32; i++) cyc(1'b1, 1'b0);
    check("attr_phase", attr_ph, 4'd3);
    check("bitmap_phase", bmp_ph, 4'd5);
    check("clkcpu_period", rise_gap, 4);
    check("no_stall_free", stall_seen, 1'b0);

    // blanked line: no video activity
    activity = 1'b0;
    for (int i = 0; i < 64; i++) cyc(1'b0, 1'b0);
    check("blank_quiet", activity, 1'b0);

    // contended CPU held across a fetch window; q rises at phase 1
    nc_stall = 1'b0;
    last_stall = 0;
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1);
    check("stall_len", last_stall, 6);
    check("nocontend_free", nc_stall, 1'b0);

    // contention only at the phase-9 rise is outside the window
    stall_seen = 1'b0;
    for (int i = 0; i < 16; i++) cyc(1'b1, ph == 4'd9);
    check("no_stall_ph9", stall_seen, 1'b0);

    // reset while in BITMAP with the CPU stalled
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1);
    check("pre_reset_stall", cpu_stall, 1'b1);
    do_reset("reset_midslot");
    attr_cnt = 0;
    bmp_cnt = 0;
    while (ph != 4'd0) cyc(1'b1, 1'b0);
    check("no_stray_bitmap", bmp_cnt, 0);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0);
    check("attr_after_reset", attr_ph, 4'd3);
    check("attr_count_after_reset", attr_cnt, 1);

    // randomised contention, fetch_en constant per window
    max_stall = 0;
    for (int w = 0; w < 1000; w++) begin
      logic fe;
      fe = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 16; i++) cyc(fe, 1'($urandom_range(0, 1)));
    end
    check("stall_max", max_stall <= 8, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
